// File: rtl/pwm_3phase_deadtime.sv
// rtl/pwm_3phase_deadtime.sv - center-aligned three-phase PWM modulator with dead-time insertion
// Duties are double-buffered to the carrier valley; a sticky fault forces all gates off.
module pwm_3phase_deadtime #(
  parameter int N    = 6,
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic [N-1:0]    carrier,
  input  logic [N-1:0]    duty_a,
  input  logic [N-1:0]    duty_b,
  input  logic [N-1:0]    duty_c,
  input  logic            duty_load,
  input  logic [DT_W-1:0] deadtime,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            ah,
  output logic            al,
  output logic            bh,
  output logic            bl,
  output logic            ch,
  output logic            cl,
  output logic            valley_sync,
  output logic            faulted
);

  typedef enum logic [1:0] {LOW_ON, HIGH_ON, DEAD, FAULT} state_t;

  localparam logic [N-1:0]    C_MAX  = '1;
  localparam logic [DT_W-1:0] DT_ONE = 1;

  logic [2:0][N-1:0] duty_in;
  logic [2:0][N-1:0] pend;
  logic [2:0][N-1:0] act;
  logic [N-1:0]      prev_car;
  logic [2:0]        raw;
  logic [2:0]        gate_h;
  logic [2:0]        gate_l;
  logic              valley_entry;
  logic              clr_go;
  logic [DT_W-1:0]   dt_m1;

  assign duty_in      = {duty_c, duty_b, duty_a};
  assign valley_entry = en && (carrier == '0) && (prev_car != '0);
  assign clr_go       = !fault && fault_clr && faulted;
  // Saturate so a zero dead time never wraps the counter to its maximum.
  assign dt_m1        = (deadtime == '0) ? '0 : deadtime - DT_ONE;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pend        <= '0;
      act         <= '0;
      raw         <= '0;
      prev_car    <= C_MAX;
      valley_sync <= 1'b0;
    end else begin
      valley_sync <= valley_entry;
      if (duty_load)
        pend <= duty_in;
      if (valley_entry)
        act <= pend;
      if (en) begin
        prev_car <= carrier;
        for (int i = 0; i < 3; i++)
          raw[i] <= (carrier < act[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)
      faulted <= 1'b0;
    else if (fault)
      faulted <= 1'b1;
    else if (fault_clr)
      faulted <= 1'b0;
  end

  for (genvar i = 0; i < 3; i++) begin : g_phase
    state_t          st;
    state_t          nst;
    logic            tgt;
    logic            ntgt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] ncnt;
    logic            hq;
    logic            lq;

    always_comb begin
      nst  = st;
      ntgt = tgt;
      ncnt = cnt;
      if (fault) begin
        nst = FAULT;
      end else if (clr_go) begin
        nst  = DEAD;
        ntgt = raw[i];
        ncnt = dt_m1;
      end else if (en) begin
        case (st)
          LOW_ON, HIGH_ON: begin
            if (raw[i] != (st == HIGH_ON)) begin
              if (deadtime == '0) begin
                nst = raw[i] ? HIGH_ON : LOW_ON;
              end else begin
                nst  = DEAD;
                ntgt = raw[i];
                ncnt = dt_m1;
              end
            end
          end
          DEAD: begin
            // A compare that flips back mid-count restarts the full dead time.
            if (raw[i] != tgt) begin
              ntgt = raw[i];
              ncnt = dt_m1;
            end else if (cnt == '0) begin
              nst = tgt ? HIGH_ON : LOW_ON;
            end else begin
              ncnt = cnt - DT_ONE;
            end
          end
          default: nst = FAULT;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!nrst) begin
        st  <= DEAD;
        tgt <= 1'b0;
        cnt <= '0;
        hq  <= 1'b0;
        lq  <= 1'b0;
      end else begin
        st  <= nst;
        tgt <= ntgt;
        cnt <= ncnt;
        hq  <= (nst == HIGH_ON);
        lq  <= (nst == LOW_ON);
      end
    end

    assign gate_h[i] = hq;
    assign gate_l[i] = lq;
  end

  assign ah = gate_h[0];
  assign al = gate_l[0];
  assign bh = gate_h[1];
  assign bl = gate_l[1];
  assign ch = gate_h[2];
  assign cl = gate_l[2];

endmodule

// File: doc/pwm_3phase_deadtime.md
# pwm_3phase_deadtime

Center-aligned three-phase PWM modulator with dead-time insertion for the FOC power stage. Consumes the N-bit triangular carrier from the upstream carrier generator and three duty words from the current/voltage controller, and drives the six gate signals (high/low per half-bridge). Duties are double-buffered and take effect only at the carrier valley. A sticky fault input forces all switches off.

## Interface
- `N`, 6: carrier and duty width
- `DT_W`, 4: dead-time counter width
- `clk`  in  1  clock
- `nrst`  in  1  reset, synchronous, active-low
- `en`  in  1  advance enable; same strobe that advances the carrier generator
- `carrier`  in  N  triangular carrier, 0 to 2^N-1 and back
- `duty_a`, `duty_b`, `duty_c`  in  N each  requested duty per phase
- `duty_load`  in  1  write all three duties into pending registers
- `deadtime`  in  DT_W  dead time in clk cycles; quasi-static
- `fault`  in  1  synchronous fault request, level
- `fault_clr`  in  1  clear sticky fault, pulse
- `ah`, `al`, `bh`, `bl`, `ch`, `cl`  out  1 each  gate drives, registered
- `valley_sync`  out  1  one-cycle pulse at valley entry, when active duties update
- `faulted`  out  1  sticky fault status

## Operation
- Pending registers: loaded from `duty_*` on `duty_load`, regardless of `en`.
- Valley entry: `en` high, `carrier == 0`, and previous sampled carrier != 0. On that cycle pending is copied to active and `valley_sync` pulses.
- If `duty_load` coincides with valley entry, the old pending value is transferred. The new value waits for the next valley.
- Compare, registered, per phase: `raw_x = (carrier < active_x)`. Duty 0 keeps the phase always low. Duty 2^N-1 drives it low only while the carrier is at its peak.
- Per-phase FSM with states LOW_ON, HIGH_ON, DEAD and FAULT. Each phase also holds `target` and a DT_W-bit `cnt`.
  - LOW_ON drives `xl=1`. HIGH_ON drives `xh=1`. DEAD and FAULT drive both low. Outputs are decoded into registers from the next state, so they never glitch.
  - HIGH_ON/LOW_ON, `raw_x` opposite to the current side:
    - `deadtime == 0`: go directly to the opposite ON state.
    - otherwise: go to DEAD with `target = raw_x` and `cnt = deadtime-1`.
  - DEAD, `raw_x != target`: set `target = raw_x`, reload `cnt = deadtime-1`, stay in DEAD.
  - DEAD, `cnt == 0`: go to the `target` ON state. Otherwise decrement `cnt`.
  - Invariant: `xh & xl` is never 1.
- Fault:
  - `fault` high forces all phases to FAULT and sets `faulted`. This does not depend on `en`.
  - `fault_clr` while `fault` is low and `faulted` is set: clear `faulted`. All phases go to DEAD with `target = raw_x` and `cnt = max(deadtime,1)-1`.
  - `fault` and `fault_clr` in the same cycle: fault wins.
- `en` low: compare registers, FSMs, counters and valley detection hold, and outputs hold. Fault handling and `duty_load` still act.
- Reset values:
  - all gate outputs 0, `valley_sync` 0, `faulted` 0
  - pending and active duties 0
  - all `raw_x` 0
  - FSMs in DEAD with `target = 0` and `cnt = 0`
  - previous-carrier register 2^N-1
- After reset, the first enabled cycle enters LOW_ON. Reset mid-dead-time abandons the count.

## Timing
- Carrier from the upstream generator dwells 2 enabled cycles at 0 and at 2^N-1. Period is 2^(N+1) enabled cycles, 128 for N=6.
- `valley_sync` is asserted the cycle after the carrier sample equal to 0 is first seen.
- Duties and compare: active duty is visible to the compare in the cycle after the valley update, so the first compare sample using the new duty is the second `carrier == 0` sample.
- Latency, carrier sample to `raw_x`: 1 cycle. `raw_x` to gate output: 1 cycle. Total 2 cycles with `deadtime == 0`.
- Latency with dead time: both gates low for exactly `deadtime` cycles before the new side rises.
- `fault` sampled at edge k: all gates 0 and `faulted` 1 after edge k. Combinational-free, one-cycle response.

## Test plan
- Nominal PWM, N=6, deadtime=0, duty_a=32, carrier from the generator: `ah` high for 64 of 128 cycles, symmetric about the valley; `al` is its exact complement, delayed 2 cycles from the carrier.
- Dead time = 3, duty_a=32: at every edge, both `ah` and `al` are 0 for exactly 3 cycles; high pulse is 61 cycles; `ah & al` never 1.
- Duty extremes: duty 0 keeps `al` high and `ah` never rises. Duty 63 with deadtime=0 gives `al` high 2 cycles per period, at the peak.
- Double buffering: `duty_load` of 48 mid-period gives no change until the valley. `duty_load` on the valley-entry cycle applies one period late. `valley_sync` gives exactly one pulse per 128 cycles.
- Fault:
  - `fault` mid-HIGH_ON: all outputs 0 the next cycle, `faulted` 1.
  - `fault_clr` with `fault` still high: ignored.
  - `fault_clr` after release, deadtime=3: both gates low for 3 cycles, then the phase follows `raw_x`.
- Glitch and enable: `raw_x` toggled back during DEAD restarts the 3-cycle count. `en` low mid-DEAD freezes `cnt` and the outputs. `nrst` mid-operation returns all gates to 0 and leaves LOW_ON one enabled cycle after release.
